// File: rtl/music_player_multi.sv
// Multi-song note sequencer: fetches note words from a same-cycle song memory
// and plays each as a square wave for a scaled duration, with rests, loop, pause and stop.
module music_player_multi #(
  parameter int unsigned NUM_NOTES = 7,
  parameter int unsigned PERIOD_W  = 8,
  parameter int unsigned DUR_W     = 16,
  parameter int unsigned SONG_W    = 5,
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DUR_W-1:0]              note_duration,
  input  logic [NUM_NOTES*PERIOD_W-1:0] note_periods,
  input  logic [SONG_W-1:0]             song_sel,
  input  logic                          start_song,
  input  logic                          stop,
  input  logic                          pause,
  input  logic                          loop_en,
  output logic                          idle,
  output logic                          song_done,
  output logic [3:0]                    note_sel,
  output logic [1:0]                    state,
  output logic                          note,
  output logic                          memreq_val,
  output logic [ADDR_W-1:0]             memreq_addr,
  input  logic [31:0]                   memresp_data
);

  localparam int unsigned CNT_W = DUR_W + 4;
  localparam logic [3:0] MAX_CODE = 4'(NUM_NOTES);
  localparam logic [3:0] END_CODE = 4'hF;
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_PLAY   = 2'd2,
    S_PAUSED = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                exh_q, exh_d;
  logic [CNT_W-1:0]    dur_q, dur_d;
  logic [PERIOD_W-1:0] hp_q, hp_d;
  logic                wave_q, wave_d;
  logic [3:0]          note_sel_q, note_sel_d;
  logic                done_q, done_d;

  logic [3:0]          code;
  logic [3:0]          mult;
  logic [CNT_W-1:0]    scaled_dur;
  logic                code_valid;
  logic [PERIOD_W-1:0] cur_period;
  logic                step;
  logic                unused_data;

  assign unused_data = ^memresp_data[31:8];

  // Decode the fetched word and select the half-period of the note now playing
  always_comb begin
    code       = memresp_data[3:0];
    mult       = (memresp_data[7:4] == 4'd0) ? 4'd1 : memresp_data[7:4];
    scaled_dur = CNT_W'(note_duration) * CNT_W'(mult);
    code_valid = (code != 4'd0) && (code <= MAX_CODE);
    cur_period = '0;
    for (int unsigned i = 0; i < NUM_NOTES; i++) begin
      if (note_sel_q == 4'(i + 1)) cur_period = note_periods[i*PERIOD_W +: PERIOD_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath update; stop overrides start, start overrides pause
  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    idx_d      = idx_q;
    exh_d      = exh_q;
    dur_d      = dur_q;
    hp_d       = hp_q;
    wave_d     = wave_q;
    note_sel_d = note_sel_q;
    done_d     = 1'b0;
    step       = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (exh_q || (code == END_CODE)) begin
          done_d = 1'b1;
          if (loop_en && !((idx_q == '0) && !exh_q)) begin
            idx_d = '0;
            exh_d = 1'b0;
          end else begin
            state_d    = S_IDLE;
            note_sel_d = 4'd0;
          end
        end else begin
          note_sel_d = code_valid ? code : 4'd0;
          dur_d      = (scaled_dur == '0) ? CNT_W'(1) : scaled_dur;
          hp_d       = '0;
          wave_d     = 1'b0;
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        if (pause) state_d = S_PAUSED;
        else       step    = 1'b1;
      end
      S_PAUSED: begin
        if (!pause) begin
          state_d = S_PLAY;
          step    = 1'b1;
        end
      end
      default: ;
    endcase

    // One playback cycle: advance duration and the square-wave phase
    if (step) begin
      dur_d = dur_q - CNT_W'(1);
      if ((note_sel_q != 4'd0) && (cur_period != '0)) begin
        if (hp_q == cur_period - PERIOD_W'(1)) begin
          wave_d = ~wave_q;
          hp_d   = '0;
        end else begin
          hp_d = hp_q + PERIOD_W'(1);
        end
      end else begin
        wave_d = 1'b0;
      end
      if (dur_q == CNT_W'(1)) begin
        state_d = S_FETCH;
        wave_d  = 1'b0;
        if (idx_q == IDX_MAX) exh_d = 1'b1;
        else                  idx_d = idx_q + IDX_W'(1);
      end
    end

    if (start_song) begin
      song_d  = song_sel;
      idx_d   = '0;
      exh_d   = 1'b0;
      wave_d  = 1'b0;
      done_d  = 1'b0;
      state_d = S_FETCH;
    end

    if (stop) begin
      state_d    = S_IDLE;
      wave_d     = 1'b0;
      note_sel_d = 4'd0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      song_q     <= '0;
      idx_q      <= '0;
      exh_q      <= 1'b0;
      dur_q      <= '0;
      hp_q       <= '0;
      wave_q     <= 1'b0;
      note_sel_q <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      song_q     <= song_d;
      idx_q      <= idx_d;
      exh_q      <= exh_d;
      dur_q      <= dur_d;
      hp_q       <= hp_d;
      wave_q     <= wave_d;
      note_sel_q <= note_sel_d;
      done_q     <= done_d;
    end
  end

  // Wave phase is kept across a pause but only reaches the pin while playing
  always_comb begin
    idle        = (state_q == S_IDLE);
    memreq_val  = (state_q == S_FETCH);
    state       = state_q;
    note        = wave_q && (state_q == S_PLAY);
    song_done   = done_q;
    note_sel    = note_sel_q;
    memreq_addr = ADDR_W'({song_q, idx_q});
  end

endmodule

// File: tb/tb_music_player_multi.sv
// Directed bench for music_player_multi with a same-cycle song memory model.
module tb_music_player_multi;

  localparam int unsigned NUM_NOTES = 7;
  localparam int unsigned PERIOD_W  = 8;
  localparam int unsigned DUR_W     = 16;
  localparam int unsigned SONG_W    = 5;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned ADDR_W    = 16;

  logic                          clk;
  logic                          rst;
  logic [DUR_W-1:0]              note_duration;
  logic [NUM_NOTES*PERIOD_W-1:0] note_periods;
  logic [SONG_W-1:0]             song_sel;
  logic                          start_song;
  logic                          stop;
  logic                          pause;
  logic                          loop_en;
  logic                          idle;
  logic                          song_done;
  logic [3:0]                    note_sel;
  logic [1:0]                    state;
  logic                          note;
  logic                          memreq_val;
  logic [ADDR_W-1:0]             memreq_addr;
  logic [31:0]                   memresp_data;

  logic [31:0] mem [0:1023];
  int checks;
  int errors;

  music_player_multi #(
    .NUM_NOTES(NUM_NOTES), .PERIOD_W(PERIOD_W), .DUR_W(DUR_W),
    .SONG_W(SONG_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .note_duration(note_duration), .note_periods(note_periods),
    .song_sel(song_sel), .start_song(start_song), .stop(stop), .pause(pause),
    .loop_en(loop_en), .idle(idle), .song_done(song_done), .note_sel(note_sel),
    .state(state), .note(note), .memreq_val(memreq_val), .memreq_addr(memreq_addr),
    .memresp_data(memresp_data)
  );

  assign memresp_data = (memreq_addr < 16'd1024) ? mem[memreq_addr[9:0]] : 32'h0000_000F;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_000F;
  endtask

  task automatic pulse_start(input logic [SONG_W-1:0] s);
    song_sel   = s;
    start_song = 1'b1;
    @(negedge clk);
    start_song = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (idle !== 1'b1 || state !== 2'd0 || note !== 1'b0 || memreq_val !== 1'b0 ||
        memreq_addr !== 16'h0 || song_done !== 1'b0 || note_sel !== 4'd0) begin
      errors++;
      $display("FAIL reset idle=%b state=%0d note=%b val=%b addr=%h done=%b sel=%0d exp 1/0/0/0/0000/0/0",
               idle, state, note, memreq_val, memreq_addr, song_done, note_sel);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_wave;
    exp_wave = 8'b0011_1000;
    clear_mem();
    mem[0] = 32'h21; mem[1] = 32'h0F;
    note_duration = 16'd4; loop_en = 1'b0;
    pulse_start(5'd0);
    checks++;
    if (state !== 2'd1 || memreq_val !== 1'b1 || memreq_addr !== 16'h0000) begin
      errors++;
      $display("FAIL single_fetch0 state=%0d val=%b addr=%h exp 1/1/0000", state, memreq_val, memreq_addr);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      checks++;
      if (state !== 2'd2 || note !== exp_wave[j] || note_sel !== 4'd1) begin
        errors++;
        $display("FAIL single_play%0d state=%0d note=%b sel=%0d exp 2/%b/1", j, state, note, note_sel, exp_wave[j]);
      end
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || memreq_addr !== 16'h0001) begin
      errors++;
      $display("FAIL single_fetch1 state=%0d addr=%h exp 1/0001", state, memreq_addr);
    end
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || song_done !== 1'b1 || note_sel !== 4'd0) begin
      errors++;
      $display("FAIL single_end idle=%b done=%b sel=%0d exp 1/1/0", idle, song_done, note_sel);
    end
    @(negedge clk);
    checks++;
    if (song_done !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL single_done_pulse done=%b idle=%b exp 0/1", song_done, idle);
    end
  endtask

  task automatic test_loop();
    int idle_seen;
    int done_cnt;
    idle_seen = 0; done_cnt = 0;
    clear_mem();
    mem[0] = 32'h21; mem[1] = 32'h0F;
    note_duration = 16'd4; loop_en = 1'b1;
    pulse_start(5'd0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (idle) idle_seen++;
      if (song_done) done_cnt++;
      if (c == 9 || c == 19) begin
        checks++;
        if (state !== 2'd1 || memreq_addr !== 16'h0001) begin
          errors++;
          $display("FAIL loop_fetch1_c%0d state=%0d addr=%h exp 1/0001", c, state, memreq_addr);
        end
      end
      if (c == 10 || c == 20) begin
        checks++;
        if (state !== 2'd1 || memreq_addr !== 16'h0000 || song_done !== 1'b1) begin
          errors++;
          $display("FAIL loop_wrap_c%0d state=%0d addr=%h done=%b exp 1/0000/1", c, state, memreq_addr, song_done);
        end
      end
    end
    checks++;
    if (idle_seen !== 0 || done_cnt !== 2) begin
      errors++;
      $display("FAIL loop_counts idle_seen=%0d done_cnt=%0d exp 0/2", idle_seen, done_cnt);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; loop_en = 1'b0;
    checks++;
    if (idle !== 1'b1 || song_done !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop idle=%b done=%b exp 1/0", idle, song_done);
    end
  endtask

  task automatic test_rest();
    clear_mem();
    mem[32'h100] = 32'h10; mem[32'h101] = 32'h0F;
    note_duration = 16'd0; loop_en = 1'b0;
    pulse_start(5'd1);
    checks++;
    if (state !== 2'd1 || memreq_addr !== 16'h0100) begin
      errors++;
      $display("FAIL rest_fetch state=%0d addr=%h exp 1/0100", state, memreq_addr);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd2 || note !== 1'b0 || note_sel !== 4'd0) begin
      errors++;
      $display("FAIL rest_play state=%0d note=%b sel=%0d exp 2/0/0", state, note, note_sel);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || memreq_addr !== 16'h0101) begin
      errors++;
      $display("FAIL rest_next state=%0d addr=%h exp 1/0101", state, memreq_addr);
    end
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || song_done !== 1'b1) begin
      errors++;
      $display("FAIL rest_end idle=%b done=%b exp 1/1", idle, song_done);
    end
    @(negedge clk);
  endtask

  task automatic test_pause();
    clear_mem();
    mem[0] = 32'h21; mem[1] = 32'h0F;
    note_duration = 16'd4; loop_en = 1'b0;
    pulse_start(5'd0);
    @(negedge clk);
    @(negedge clk);
    pause = 1'b1;
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (state !== 2'd3 || note !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold%0d state=%0d note=%b exp 3/0", k, state, note);
      end
    end
    pause = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd2 || note !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume state=%0d note=%b exp 2/0", state, note);
    end
    @(negedge clk);
    checks++;
    if (note !== 1'b1) begin
      errors++;
      $display("FAIL pause_rise note=%b exp 1", note);
    end
    for (int c = 10; c <= 13; c++) @(negedge clk);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL pause_still_play state=%0d exp 2", state);
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || memreq_addr !== 16'h0001) begin
      errors++;
      $display("FAIL pause_note_end state=%0d addr=%h exp 1/0001", state, memreq_addr);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_stop();
    int bad;
    bad = 0;
    clear_mem();
    mem[0] = 32'h21; mem[1] = 32'h0F;
    note_duration = 16'd4; loop_en = 1'b0;
    pulse_start(5'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || idle !== 1'b1 || note !== 1'b0 || note_sel !== 4'd0 || song_done !== 1'b0) begin
      errors++;
      $display("FAIL stop_play state=%0d idle=%b note=%b sel=%0d done=%b exp 0/1/0/0/0",
               state, idle, note, note_sel, song_done);
    end
    start_song = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || memreq_val !== 1'b0 || song_done !== 1'b0) begin
      errors++;
      $display("FAIL stop_vs_start state=%0d val=%b done=%b exp 0/0/0", state, memreq_val, song_done);
    end
    stop = 1'b0; start_song = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (song_done !== 1'b0 || idle !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stop_quiet bad_cycles=%0d exp 0", bad);
    end
  endtask

  task automatic test_empty();
    clear_mem();
    note_duration = 16'd4; loop_en = 1'b1;
    pulse_start(5'd2);
    checks++;
    if (state !== 2'd1 || memreq_addr !== 16'h0200) begin
      errors++;
      $display("FAIL empty_fetch state=%0d addr=%h exp 1/0200", state, memreq_addr);
    end
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || song_done !== 1'b1) begin
      errors++;
      $display("FAIL empty_end idle=%b done=%b exp 1/1", idle, song_done);
    end
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || song_done !== 1'b0) begin
      errors++;
      $display("FAIL empty_after idle=%b done=%b exp 1/0", idle, song_done);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_async_reset();
    clear_mem();
    mem[0] = 32'h21; mem[1] = 32'h0F;
    note_duration = 16'd4; loop_en = 1'b0;
    pulse_start(5'd0);
    for (int c = 0; c < 5; c++) @(negedge clk);
    checks++;
    if (state !== 2'd2 || note !== 1'b1 || note_sel !== 4'd1) begin
      errors++;
      $display("FAIL areset_pre state=%0d note=%b sel=%0d exp 2/1/1", state, note, note_sel);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (idle !== 1'b1 || state !== 2'd0 || note !== 1'b0 || memreq_val !== 1'b0 ||
        memreq_addr !== 16'h0 || song_done !== 1'b0 || note_sel !== 4'd0) begin
      errors++;
      $display("FAIL areset idle=%b state=%0d note=%b val=%b addr=%h done=%b sel=%0d exp 1/0/0/0/0000/0/0",
               idle, state, note, memreq_val, memreq_addr, song_done, note_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(5'd0);
    checks++;
    if (state !== 2'd1 || memreq_addr !== 16'h0000) begin
      errors++;
      $display("FAIL areset_restart state=%0d addr=%h exp 1/0000", state, memreq_addr);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; note_duration = '0; song_sel = '0;
    start_song = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    note_periods = '0;
    note_periods[PERIOD_W-1:0] = 8'd3;
    clear_mem();
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_single();
    test_loop();
    test_rest();
    test_pause();
    test_stop();
    test_empty();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
